// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter
// Packet-level round-robin arbiter: N AXI-Stream sources share one registered
// 32-bit AXI-Stream master. A grant is held from a packet's first beat to its
// TLAST beat, so packets never interleave. TUSER[0] is regenerated as the
// first-beat marker and TDEST is latched from the first beat of each packet.
// Optional feature macro: AXIS_ARB_TIMEOUT_EN adds a mid-packet idle timeout
// that emits a 32'hDEAD_BEEF error beat, counts the abort and flushes the rest
// of the stalled packet.
module axis_pkt_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [32*N-1:0] s_tdata,
    input  logic [N-1:0]    s_tlast,
    input  logic [8*N-1:0]  s_tdest,
    input  logic [4*N-1:0]  s_tuser,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [31:0]     m_tdata,
    output logic            m_tlast,
    output logic [7:0]      m_tdest,
    output logic [3:0]      m_tuser,
    output logic [N-1:0]    grant,
    output logic [15:0]     abort_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef AXIS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_ERR, ST_FLUSH} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_PASS} state_t;
`endif

    state_t        r_state;
    logic [IW-1:0] r_gidx;
    logic [IW-1:0] r_last_grant;
    logic [N-1:0]  r_grant;
    logic          r_first;
    logic          r_m_tvalid;
    logic [31:0]   r_m_tdata;
    logic          r_m_tlast;
    logic [7:0]    r_m_tdest;
    logic [3:0]    r_m_tuser;
`ifdef AXIS_ARB_TIMEOUT_EN
    logic [15:0]   r_abort_cnt;
    logic [TW-1:0] r_tmo;
`else
    logic          w_unused_timeout;
`endif

    logic          w_sel_valid;
    logic          w_sel_last;
    logic [31:0]   w_sel_data;
    logic [7:0]    w_sel_dest;
    logic [2:0]    w_sel_user;
    logic          w_sel_ready;
    logic          w_out_free;
    logic          w_accept;
    logic [IW-1:0] w_pick;

    // First requester after 'last' in wrap-around order; 'last' itself has lowest priority.
    function automatic logic [IW-1:0] f_rr_pick(input logic [N-1:0] req, input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        int            idx;
        pick = last;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) pick = IW'(idx);
        end
        return pick;
    endfunction

    // Granted-source mux and combinational TREADY (no register between m_tready and s_tready).
    always_comb begin
        w_sel_valid = s_tvalid[r_gidx];
        w_sel_last  = s_tlast[r_gidx];
        w_sel_data  = s_tdata[32*int'(r_gidx) +: 32];
        w_sel_dest  = s_tdest[8*int'(r_gidx) +: 8];
        w_sel_user  = s_tuser[4*int'(r_gidx)+1 +: 3];
        w_out_free  = !r_m_tvalid || m_tready;
        w_pick      = f_rr_pick(s_tvalid, r_last_grant);
        w_sel_ready = 1'b0;
        if (r_state == ST_PASS) begin
            w_sel_ready = w_out_free;
        end
`ifdef AXIS_ARB_TIMEOUT_EN
        else if (r_state == ST_FLUSH) begin
            w_sel_ready = 1'b1;
        end
`endif
        s_tready         = '0;
        s_tready[r_gidx] = w_sel_ready;
        w_accept         = w_sel_valid && w_sel_ready;
    end

    // Arbitration FSM together with the registered master output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_gidx       <= '0;
            r_last_grant <= IW'(N - 1);
            r_grant      <= '0;
            r_first      <= 1'b0;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tlast    <= 1'b0;
            r_m_tdest    <= '0;
            r_m_tuser    <= '0;
`ifdef AXIS_ARB_TIMEOUT_EN
            r_abort_cnt  <= '0;
            r_tmo        <= '0;
`endif
        end else begin
            // Downstream took the held beat; a load below overrides this.
            if (m_tready) r_m_tvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|s_tvalid) begin
                        r_gidx  <= w_pick;
                        r_grant <= N'(1) << w_pick;
                        r_first <= 1'b1;
                        r_state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_accept) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= w_sel_data;
                        r_m_tlast  <= w_sel_last;
                        r_m_tuser  <= {w_sel_user, r_first};
                        if (r_first) r_m_tdest <= w_sel_dest;
                        r_first    <= 1'b0;
`ifdef AXIS_ARB_TIMEOUT_EN
                        r_tmo      <= '0;
`endif
                        if (w_sel_last) begin
                            r_last_grant <= r_gidx;
                            r_grant      <= '0;
                            r_state      <= ST_IDLE;
                        end
                    end
`ifdef AXIS_ARB_TIMEOUT_EN
                    else if (!w_sel_valid && !r_first) begin
                        if (r_tmo == TW'(TIMEOUT - 1)) begin
                            r_tmo   <= '0;
                            r_state <= ST_ERR;
                        end else begin
                            r_tmo <= r_tmo + TW'(1);
                        end
                    end
`endif
                end
`ifdef AXIS_ARB_TIMEOUT_EN
                ST_ERR: begin
                    // Error beat keeps the packet's latched TDEST.
                    if (w_out_free) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= 32'hDEAD_BEEF;
                        r_m_tlast  <= 1'b1;
                        r_m_tuser  <= 4'b0010;
                        if (r_abort_cnt != 16'hFFFF) r_abort_cnt <= r_abort_cnt + 16'd1;
                        r_state    <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Remaining beats of the aborted packet are accepted and dropped.
                    if (w_accept && w_sel_last) begin
                        r_last_grant <= r_gidx;
                        r_grant      <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_tlast  = r_m_tlast;
    assign m_tdest  = r_m_tdest;
    assign m_tuser  = r_m_tuser;
    assign grant    = r_grant;
`ifdef AXIS_ARB_TIMEOUT_EN
    assign abort_cnt = r_abort_cnt;
`else
    assign abort_cnt        = '0;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: a per-cycle vector table,
// hand sequences for async reset and timeout abort, and randomized traffic
// scored against a packet-level round-robin reference.
`timescale 1ns/1ps
module tb_axis_pkt_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [32*N-1:0] s_tdata;
    logic [N-1:0]    s_tlast;
    logic [8*N-1:0]  s_tdest;
    logic [4*N-1:0]  s_tuser;
    logic            m_tvalid;
    logic            m_tready;
    logic [31:0]     m_tdata;
    logic            m_tlast;
    logic [7:0]      m_tdest;
    logic [3:0]      m_tuser;
    logic [N-1:0]    grant;
    logic [15:0]     abort_cnt;

    axis_pkt_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tlast(s_tlast), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant(grant), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          src;
        logic        vld;
        logic [31:0] data;
        logic        last;
        logic [7:0]  dest;
        logic [3:0]  user;
        logic        mready;
        logic [N-1:0] exp_sready;
        logic        exp_mvalid;
        logic [31:0] exp_mdata;
        logic        exp_mlast;
        logic [3:0]  exp_muser;
        logic [7:0]  exp_mdest;
        logic [N-1:0] exp_grant;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
        logic [7:0]  dest;
        logic [3:0]  user;
    } beat_t;

    vec_t  tbl[9];
    beat_t src_q[N][$];
    beat_t ref_q[N][$];
    beat_t exp_q[$];
    int    gap[N];
    logic [N-1:0] acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int src, input logic vld, input logic [31:0] d, input logic last,
                         input logic [7:0] dest, input logic [3:0] user);
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tdest = '0; s_tuser = '0;
        s_tvalid[src]           = vld;
        s_tdata[32*src +: 32]   = d;
        s_tlast[src]            = last;
        s_tdest[8*src +: 8]     = dest;
        s_tuser[4*src +: 4]     = user;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t bt, eb, ob;
        logic [45:0] cur, saved;
        logic stall_prev, first, lastb;
        logic [7:0] dest0;
        int last_src, s, len, low;
        logic found;

        // inputs, then expected s_tready (comb) and registered outputs after the edge
        tbl[0] = '{0, 1'b1, 32'h11000001, 1'b0, 8'h5A, 4'h6, 1'b1, 4'b0000, 1'b0, 32'h0,        1'b0, 4'h0, 8'h00, 4'b0001};
        tbl[1] = '{0, 1'b1, 32'h11000001, 1'b0, 8'h5A, 4'h6, 1'b1, 4'b0001, 1'b1, 32'h11000001, 1'b0, 4'h7, 8'h5A, 4'b0001};
        tbl[2] = '{0, 1'b1, 32'h11000002, 1'b0, 8'h77, 4'h6, 1'b1, 4'b0001, 1'b1, 32'h11000002, 1'b0, 4'h6, 8'h5A, 4'b0001};
        tbl[3] = '{0, 1'b1, 32'h11000003, 1'b1, 8'h77, 4'h6, 1'b1, 4'b0001, 1'b1, 32'h11000003, 1'b1, 4'h6, 8'h5A, 4'b0000};
        tbl[4] = '{0, 1'b0, 32'h0,        1'b0, 8'h00, 4'h0, 1'b1, 4'b0000, 1'b0, 32'h11000003, 1'b1, 4'h6, 8'h5A, 4'b0000};
        tbl[5] = '{2, 1'b1, 32'h22220001, 1'b1, 8'h22, 4'hF, 1'b1, 4'b0000, 1'b0, 32'h11000003, 1'b1, 4'h6, 8'h5A, 4'b0100};
        tbl[6] = '{2, 1'b1, 32'h22220001, 1'b1, 8'h22, 4'hF, 1'b1, 4'b0100, 1'b1, 32'h22220001, 1'b1, 4'hF, 8'h22, 4'b0000};
        tbl[7] = '{2, 1'b0, 32'h0,        1'b0, 8'h00, 4'h0, 1'b0, 4'b0000, 1'b1, 32'h22220001, 1'b1, 4'hF, 8'h22, 4'b0000};
        tbl[8] = '{2, 1'b0, 32'h0,        1'b0, 8'h00, 4'h0, 1'b1, 4'b0000, 1'b0, 32'h22220001, 1'b1, 4'hF, 8'h22, 4'b0000};

        rst_n = 1'b0; m_tready = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0, 8'h0, 4'h0);
        repeat (2) @(negedge clk);
        check("reset_out", 64'({m_tvalid, m_tlast, m_tuser, m_tdest, m_tdata}), 64'(0));
        check("reset_ctl", 64'({grant, s_tready, abort_cnt}), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(tbl[i].src, tbl[i].vld, tbl[i].data, tbl[i].last, tbl[i].dest, tbl[i].user);
            m_tready = tbl[i].mready;
            #1;
            check($sformatf("tbl%0d_sready", i), 64'(s_tready), 64'(tbl[i].exp_sready));
            @(posedge clk); #1;
            check($sformatf("tbl%0d_out", i),
                  64'({m_tvalid, m_tlast, m_tuser, m_tdest, m_tdata, grant}),
                  64'({tbl[i].exp_mvalid, tbl[i].exp_mlast, tbl[i].exp_muser, tbl[i].exp_mdest,
                       tbl[i].exp_mdata, tbl[i].exp_grant}));
        end

        // Asynchronous reset in the middle of a source-3 packet
        @(negedge clk);
        drive(3, 1'b1, 32'h33330001, 1'b0, 8'h33, 4'h0);
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst", 64'({m_tvalid, m_tdata, grant}), 64'({1'b1, 32'h33330001, 4'b1000}));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out", 64'({m_tvalid, m_tlast, m_tuser, m_tdest, m_tdata}), 64'(0));
        check("rst_async_ctl", 64'({grant, s_tready, abort_cnt}), 64'(0));
        s_tvalid = '1; s_tlast = '1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_after_rst", 64'(grant), 64'(4'b0001));
        drive(0, 1'b0, 32'h0, 1'b0, 8'h0, 4'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic: 3 packets per source, all requesting from the start
        for (int k = 0; k < N; k++) begin
            for (int p = 0; p < 3; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    bt.d = $urandom; bt.last = (b == len - 1);
                    bt.dest = 8'($urandom); bt.user = 4'($urandom);
                    src_q[k].push_back(bt);
                    ref_q[k].push_back(bt);
                end
            end
            gap[k] = 0;
        end
        last_src = N - 1;
        forever begin
            found = 1'b0;
            s = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && ref_q[(last_src + k) % N].size() > 0) begin
                    s = (last_src + k) % N;
                    found = 1'b1;
                end
            end
            if (!found) break;
            first = 1'b1;
            dest0 = ref_q[s][0].dest;
            do begin
                bt = ref_q[s].pop_front();
                eb.d = bt.d; eb.last = bt.last; eb.dest = dest0;
                eb.user = {bt.user[3:1], first};
                exp_q.push_back(eb);
                first = 1'b0;
            end while (!bt.last);
            last_src = s;
        end

        stall_prev = 1'b0;
        saved = '0;
        for (int cyc = 0; cyc < 4000 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            cur = {m_tvalid, m_tdata, m_tlast, m_tuser, m_tdest};
            if (stall_prev) check("stall_hold", 64'(cur), 64'(saved));
            s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tdest = '0; s_tuser = '0;
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() > 0 && gap[k] == 0) begin
                    s_tvalid[k]         = 1'b1;
                    s_tdata[32*k +: 32] = src_q[k][0].d;
                    s_tlast[k]          = src_q[k][0].last;
                    s_tdest[8*k +: 8]   = src_q[k][0].dest;
                    s_tuser[4*k +: 4]   = src_q[k][0].user;
                end
            end
            m_tready = ($urandom_range(0, 3) != 0);
            #1;
            acc = s_tvalid & s_tready;
            if (m_tvalid && m_tready) begin
                ob = {m_tdata, m_tlast, m_tdest, m_tuser};
                if (exp_q.size() == 0) check("rand_extra_beat", 64'(ob), 64'(0));
                else begin
                    eb = exp_q.pop_front();
                    check("rand_beat", 64'(ob), 64'(eb));
                end
            end
            stall_prev = m_tvalid && !m_tready;
            if (stall_prev) begin
                check("stall_sready", 64'(s_tready), 64'(0));
                saved = cur;
            end
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    lastb = src_q[k][0].last;
                    void'(src_q[k].pop_front());
                    gap[k] = lastb ? 0 : $urandom_range(0, 2);
                end else if (gap[k] > 0) begin
                    gap[k]--;
                end
            end
        end
        check("rand_drain", 64'(exp_q.size()), 64'(0));

`ifdef AXIS_ARB_TIMEOUT_EN
        // Source 1 stalls mid-packet; source 2 is waiting behind it
        @(negedge clk);
        drive(1, 1'b1, 32'h000000A1, 1'b0, 8'h31, 4'h0);
        s_tvalid[2] = 1'b1; s_tdata[95:64] = 32'h000000C2; s_tlast[2] = 1'b1; s_tdest[23:16] = 8'h42;
        m_tready = 1'b1;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_tvalid[1] = 1'b0;
        low = 0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            low++;
            if (m_tvalid && m_tdata == 32'hDEADBEEF) found = 1'b1;
        end
        check("tmo_seen", 64'(found), 64'(1));
        check("tmo_delay_in_range", 64'(low >= 16 && low <= 18), 64'(1));
        check("tmo_beat", 64'({m_tdata, m_tlast, m_tuser, m_tdest}), 64'({32'hDEADBEEF, 1'b1, 4'b0010, 8'h31}));
        check("tmo_abort_cnt", 64'(abort_cnt), 64'(1));
        check("tmo_grant_held", 64'(grant), 64'(4'b0010));
        s_tvalid[1] = 1'b1; s_tdata[63:32] = 32'h000000A2; s_tlast[1] = 1'b0;
        #1 check("flush_ready", 64'(s_tready), 64'(4'b0010));
        @(negedge clk);
        check("flush_drop1", 64'(m_tvalid), 64'(0));
        s_tdata[63:32] = 32'h000000A3; s_tlast[1] = 1'b1;
        @(negedge clk);
        check("flush_drop2", 64'(m_tvalid), 64'(0));
        s_tvalid[1] = 1'b0;
        @(negedge clk);
        check("post_flush_grant", 64'(grant), 64'(4'b0100));
        @(negedge clk);
        check("post_flush_beat", 64'({m_tvalid, m_tdata, m_tlast, m_tuser, m_tdest}),
              64'({1'b1, 32'h000000C2, 1'b1, 4'b0001, 8'h42}));
`else
        check("abort_cnt_zero", 64'(abort_cnt), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
